// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter: round-robin framing arbiter sharing one uart_tx among NUM_REQ byte streams
module uart_tx_frame_arbiter #(
    parameter int         NUM_REQ       = 4,
    parameter logic [3:0] HEADER_TAG    = 4'hA,
    parameter int         MAX_FRAME_LEN = 64
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [NUM_REQ-1:0]     req_valid_in,
    input  logic [8*NUM_REQ-1:0]   req_data_in,
    input  logic [NUM_REQ-1:0]     req_last_in,
    output logic [NUM_REQ-1:0]     req_ready_out,
    output logic [7:0]             tx_byte_out,
    output logic                   tx_valid_out,
    input  logic                   tx_ready_in,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic                   trunc_out
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [1:0] IDLE = 2'd0, TX_HOLD = 2'd1, TX_WAIT = 2'd2, FETCH = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] win, rr_ptr, pick;
    logic [CW-1:0] count;
    logic          done, trunc;
    logic          win_valid, win_last, at_limit;
    logic [7:0]    win_data;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p, input int k);
        return IW'((int'(p) + k) % NUM_REQ);
    endfunction

    // descending scan so the nearest valid index after rr_ptr wins
    always_comb begin
        pick = rr_ptr;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req_valid_in[nxt(rr_ptr, k)]) pick = nxt(rr_ptr, k);
    end

    assign win_valid     = req_valid_in[win];
    assign win_last      = req_last_in[win];
    assign win_data      = req_data_in[{win, 3'b000} +: 8];
    assign at_limit      = count == CW'(MAX_FRAME_LEN - 1);
    assign req_ready_out = (state == FETCH) ? grant_out : '0;
    assign busy_out      = state != IDLE;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            win            <= '0;
            rr_ptr         <= IW'(NUM_REQ - 1);
            grant_out      <= '0;
            count          <= '0;
            done           <= 1'b0;
            trunc          <= 1'b0;
            tx_byte_out    <= '0;
            tx_valid_out   <= 1'b0;
            frame_done_out <= 1'b0;
            trunc_out      <= 1'b0;
        end else begin
            tx_valid_out   <= 1'b0;
            frame_done_out <= 1'b0;
            trunc_out      <= 1'b0;
            case (state)
                IDLE: if (tx_ready_in && |req_valid_in) begin
                    win          <= pick;
                    grant_out    <= NUM_REQ'(1) << pick;
                    tx_byte_out  <= {HEADER_TAG, 4'(pick)};
                    tx_valid_out <= 1'b1;
                    count        <= '0;
                    done         <= 1'b0;
                    trunc        <= 1'b0;
                    state        <= TX_HOLD;
                end
                // uart_tx ready lags the valid pulse by a cycle
                TX_HOLD: state <= TX_WAIT;
                TX_WAIT: if (tx_ready_in) begin
                    if (done) begin
                        frame_done_out <= 1'b1;
                        trunc_out      <= trunc;
                        rr_ptr         <= win;
                        grant_out      <= '0;
                        state          <= IDLE;
                    end else begin
                        state <= FETCH;
                    end
                end
                default: if (win_valid) begin
                    tx_byte_out  <= win_data;
                    tx_valid_out <= 1'b1;
                    count        <= count + 1'b1;
                    done         <= win_last || at_limit;
                    trunc        <= !win_last && at_limit;
                    state        <= TX_HOLD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// tb_uart_tx_frame_arbiter: directed bench with a frame-level model and a uart_tx-like sink
module tb_uart_tx_frame_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int MAXLEN   = 3;
    localparam int BYTE_CYC = 12;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic [NUM_REQ-1:0]   req_valid_in, req_last_in, req_ready_out, grant_out;
    logic [8*NUM_REQ-1:0] req_data_in;
    logic [7:0]           tx_byte_out;
    logic                 tx_valid_out, tx_ready_in, busy_out, frame_done_out, trunc_out;

    uart_tx_frame_arbiter #(.NUM_REQ(NUM_REQ), .HEADER_TAG(4'hA), .MAX_FRAME_LEN(MAXLEN)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .req_valid_in(req_valid_in),
        .req_data_in(req_data_in), .req_last_in(req_last_in), .req_ready_out(req_ready_out),
        .tx_byte_out(tx_byte_out), .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
        .grant_out(grant_out), .busy_out(busy_out), .frame_done_out(frame_done_out),
        .trunc_out(trunc_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, errors = 0;
    int ncyc = 0, npulse = 0, ready0_cycles = 0, mrr = NUM_REQ - 1;
    logic [8:0] rq [NUM_REQ][$];
    logic [7:0] sq [NUM_REQ][$];
    logic [7:0] exp_line[$], line_log[$], bq[$];
    logic [3:0] exp_grant[$];
    logic       exp_trunc[$], done_log[$];
    logic [NUM_REQ-1:0] fire = '0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // expected line bytes of one complete stream, split at MAXLEN into framed chunks
    task automatic model_stream(input int ch, input logic [7:0] b[$]);
        int n = 0;
        for (int i = 0; i < b.size(); i++) begin
            if (n == 0) begin
                exp_line.push_back({4'hA, 4'(ch)});
                exp_grant.push_back(4'(1 << ch));
            end
            exp_line.push_back(b[i]);
            exp_grant.push_back(4'(1 << ch));
            n++;
            if (i == b.size() - 1) begin exp_trunc.push_back(1'b0); n = 0; end
            else if (n == MAXLEN) begin exp_trunc.push_back(1'b1); n = 0; end
        end
    endtask

    // frames for all streams pending at once, served in round-robin order from mrr
    task automatic model_rr(input logic [NUM_REQ-1:0] mask);
        int w;
        while (mask != 0) begin
            w = -1;
            for (int k = 1; k <= NUM_REQ && w < 0; k++)
                if (mask[(mrr + k) % NUM_REQ]) w = (mrr + k) % NUM_REQ;
            model_stream(w, sq[w]);
            mrr = w;
            mask[w] = 1'b0;
        end
    endtask

    task automatic send(input int ch, input logic [7:0] b[$], input bit with_last);
        for (int i = 0; i < b.size(); i++) rq[ch].push_back({with_last && i == b.size() - 1, b[i]});
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] log_word();
        logic [63:0] w = '0;
        foreach (line_log[i]) w = {w[55:0], line_log[i]};
        return w;
    endfunction

    task automatic clear_logs();
        line_log.delete();
        done_log.delete();
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 4000 && !(exp_line.size() == 0 && exp_trunc.size() == 0 && rq_empty() && !busy_out)) begin
            @(posedge clk_in); #1;
            t++;
        end
        check(t < 4000, "drain_timeout", 64'(t), 64'd4000);
    endtask

    task automatic wait_lines(input int n);
        int t = 0;
        while (t < 2000 && line_log.size() < n) begin
            @(posedge clk_in); #1;
            t++;
        end
        check(t < 2000, "line_timeout", 64'(line_log.size()), 64'(n));
    endtask

    // requester drivers: present queue heads, pop what was accepted at the last edge
    initial begin
        logic [8:0] h;
        req_valid_in = '0;
        req_data_in  = '0;
        req_last_in  = '0;
        forever begin
            @(negedge clk_in);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                h = (rq[i].size() > 0) ? rq[i][0] : 9'h0;
                req_valid_in[i]       = rq[i].size() > 0;
                req_data_in[8*i +: 8] = h[7:0];
                req_last_in[i]        = h[8];
            end
            fire = req_valid_in & req_ready_out & {NUM_REQ{rst_n_in}};
        end
    end

    // uart_tx-like sink plus the per-cycle compare against the model
    initial begin
        bit rdy_seen, prev_valid = 1'b0;
        int busy_left = 0;
        logic [7:0] eb;
        logic [3:0] eg;
        tx_ready_in = 1'b1;
        forever begin
            @(negedge clk_in);
            ncyc++;
            rdy_seen = tx_ready_in;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_ready_in = 1'b1;
            end
            check($onehot0(req_ready_out), "ready_onehot", 64'(req_ready_out), 64'd0);
            check(busy_out == (grant_out != 0), "busy_vs_grant", 64'(busy_out), 64'(grant_out != 0));
            check(!(trunc_out && !frame_done_out), "trunc_alone", 64'(trunc_out), 64'd0);
            if (req_ready_out[0]) ready0_cycles++;
            if (tx_valid_out) begin
                check(rdy_seen, "valid_without_ready", 64'(rdy_seen), 64'd1);
                check(!prev_valid, "valid_back_to_back", 64'(prev_valid), 64'd0);
                if (exp_line.size() == 0) check(1'b0, "unexpected_byte", 64'(tx_byte_out), 64'd0);
                else begin
                    eb = exp_line.pop_front();
                    eg = exp_grant.pop_front();
                    check(tx_byte_out == eb, "line_byte", 64'(tx_byte_out), 64'(eb));
                    check(grant_out == eg, "grant", 64'(grant_out), 64'(eg));
                end
                line_log.push_back(tx_byte_out);
                npulse++;
                tx_ready_in = 1'b0;
                busy_left = BYTE_CYC;
            end
            if (frame_done_out) begin
                check(grant_out == 0, "grant_at_done", 64'(grant_out), 64'd0);
                if (exp_trunc.size() == 0) check(1'b0, "unexpected_done", 64'(trunc_out), 64'd0);
                else begin
                    eb = 8'(exp_trunc.pop_front());
                    check(trunc_out == eb[0], "trunc_flag", 64'(trunc_out), 64'(eb[0]));
                end
                done_log.push_back(trunc_out);
            end
            prev_valid = tx_valid_out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycles %0d expected below 200000", ncyc);
        $fatal(1);
    end

    initial begin
        int c0, t, n0, r0;
        rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check({tx_byte_out, tx_valid_out, req_ready_out, grant_out, busy_out, frame_done_out, trunc_out} == 0,
              "reset_outputs", 64'({tx_byte_out, tx_valid_out, req_ready_out, grant_out, busy_out,
              frame_done_out, trunc_out}), 64'd0);
        rst_n_in = 1'b1;

        // round robin: 0, 2, 3 pending together from rr_ptr=3
        clear_logs();
        sq[0] = '{8'h01, 8'h02}; sq[2] = '{8'h21}; sq[3] = '{8'h31, 8'h32};
        send(0, sq[0], 1); send(2, sq[2], 1); send(3, sq[3], 1);
        model_rr(4'b1101);
        wait_idle();
        check(line_log.size() == 8 && log_word() == 64'hA00102A221A33132, "rr_order", log_word(), 64'hA00102A221A33132);
        clear_logs();
        sq[0] = '{8'h05}; sq[3] = '{8'h36};
        send(0, sq[0], 1); send(3, sq[3], 1);
        model_rr(4'b1001);
        wait_idle();
        check(line_log.size() == 4 && log_word() == 64'hA005A336, "rr_wrap", log_word(), 64'hA005A336);

        // single frame with header latency
        clear_logs();
        bq = '{8'h11, 8'h22};
        send(1, bq, 1); model_stream(1, bq); mrr = 1;
        t = 0;
        while (!req_valid_in[1] && t < 20) begin @(posedge clk_in); #1; t++; end
        c0 = ncyc; n0 = npulse; t = 0;
        while (npulse == n0 && t < 20) begin @(posedge clk_in); #1; t++; end
        check(ncyc - c0 == 1, "header_latency", 64'(ncyc - c0), 64'd1);
        wait_idle();
        check(line_log.size() == 3 && log_word() == 64'hA11122, "single_frame", log_word(), 64'hA11122);
        check(done_log.size() == 1 && done_log[0] == 1'b0, "single_done", 64'(done_log.size()), 64'd1);

        // truncation at MAXLEN=3
        clear_logs();
        bq = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        send(2, bq, 1); model_stream(2, bq); mrr = 2;
        wait_idle();
        check(line_log.size() == 7 && log_word() == 64'hA2B1B2B3A2B4B5, "trunc_line", log_word(), 64'hA2B1B2B3A2B4B5);
        check(done_log.size() == 2 && done_log[0] == 1'b1 && done_log[1] == 1'b0, "trunc_pulses",
              64'({done_log.size() == 2, done_log[0], done_log[1]}), 64'b110);

        // stall: req1 holds the frame while req0 waits
        clear_logs();
        bq = '{8'h31, 8'h32}; model_stream(1, bq);
        bq = '{8'h41};        model_stream(0, bq);
        bq = '{8'h31}; send(1, bq, 0);
        wait_lines(2);
        bq = '{8'h41}; send(0, bq, 1);
        n0 = npulse; r0 = ready0_cycles;
        repeat (200) @(posedge clk_in);
        #1;
        check(npulse == n0, "stall_no_pulse", 64'(npulse - n0), 64'd0);
        check(ready0_cycles == r0, "stall_no_ready0", 64'(ready0_cycles - r0), 64'd0);
        check(req_ready_out == 4'b0010, "stall_ready1", 64'(req_ready_out), 64'b0010);
        bq = '{8'h32}; send(1, bq, 1);
        mrr = 0;
        wait_idle();
        check(line_log.size() == 5 && log_word() == 64'hA13132A041, "stall_order", log_word(), 64'hA13132A041);

        // reset while a payload byte is still on the line
        clear_logs();
        bq = '{8'h71, 8'h72, 8'h73};
        send(3, bq, 1); model_stream(3, bq);
        wait_lines(2);
        rst_n_in = 1'b0;
        @(posedge clk_in); #1;
        check({tx_byte_out, tx_valid_out, req_ready_out, grant_out, busy_out, frame_done_out, trunc_out} == 0,
              "midframe_reset_outputs", 64'({tx_byte_out, tx_valid_out, req_ready_out, grant_out, busy_out,
              frame_done_out, trunc_out}), 64'd0);
        check(tx_ready_in == 1'b0, "sink_still_busy", 64'(tx_ready_in), 64'd0);
        rq[3].delete(); exp_line.delete(); exp_grant.delete(); exp_trunc.delete();
        mrr = NUM_REQ - 1;
        clear_logs();
        rst_n_in = 1'b1;
        bq = '{8'h5A};
        send(0, bq, 1); model_stream(0, bq);
        wait_idle();
        check(line_log.size() == 2 && log_word() == 64'hA05A, "post_reset_frame", log_word(), 64'hA05A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
